// File: rtl/dff_reg_arbiter_pkg.sv
// dff_arb_pkg: shared state encoding, defaults and slice helper for the register arbiter
package dff_arb_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int RST_PTR = DEF_NREQ - 1;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ACK = 2'd2} state_t;
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/dff_reg_arbiter_if.sv
// dff_reg_arbiter_if: requester-side bus of the shared register arbiter
interface dff_reg_arbiter_if #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0] req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic busy;
    modport master (output req, wdata, input gnt, ack, q, qb, busy);
    modport slave (input req, wdata, output gnt, ack, q, qb, busy);
endinterface

// File: rtl/dff_reg_arbiter_rr_picker.sv
// rr_picker: rotate requests so the search starts after ptr, take the lowest set bit, rotate back
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW = 2
) (
    input logic [NREQ-1:0] i_req,
    input logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_winner,
    output logic o_valid
);
    int w_start;
    int w_idx;
    logic [NREQ-1:0] w_rot;
    always_comb begin
        w_start = (int'(i_ptr) + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) w_rot[i] = i_req[(i + w_start) % NREQ];
        w_idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (w_rot[i]) w_idx = i;
        o_winner = PW'((w_idx + w_start) % NREQ);
        o_valid = |i_req;
    end
endmodule

// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter: round-robin write sequencer owning a shared WIDTH-bit q/qb register
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input logic clk,
    input logic rst,
    dff_reg_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);
    state_t r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_win;
    logic [PW-1:0] w_win;
    logic w_valid;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [WIDTH-1:0] r_q;
    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req(bus.req),
        .i_ptr(r_ptr),
        .o_winner(w_win),
        .o_valid(w_valid)
    );
    // ptr advances only once a write has been committed and acknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= PTR_INIT;
            r_win <= '0;
            r_gnt <= '0;
            r_ack <= '0;
            r_q <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_valid) begin
                    r_win <= w_win;
                    r_gnt <= NREQ'(1) << w_win;
                    r_state <= GRANT;
                end
                GRANT: if (bus.req[r_win]) begin
                    r_q <= bus.wdata[slice_lo(int'(r_win), WIDTH) +: WIDTH];
                    r_ack <= NREQ'(1) << r_win;
                    r_state <= ACK;
                end else begin
                    r_gnt <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt <= '0;
                    r_ack <= '0;
                    r_ptr <= r_win;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign bus.gnt = r_gnt;
    assign bus.ack = r_ack;
    assign bus.q = r_q;
    assign bus.qb = ~r_q;
    assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// tb_dff_reg_arbiter: directed scenarios with hand-computed {gnt,ack,q,qb,busy} expectations
module tb_dff_reg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec = 0;
    int errs = 0;
    logic [28:0] obs;
    logic [28:0] exp_v;
    dff_reg_arbiter_if #(.NREQ(4), .WIDTH(8)) b ();
    dff_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(b.slave));
    always #5 clk = ~clk;
    assign obs = {b.gnt, b.ack, b.q, b.qb, b.busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b.req = 4'b1111;
        b.wdata = 32'h44332211;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = {4'b0000, 4'b0000, 8'h00, 8'hFF, 1'b0};
            vec++;
            if (obs !== exp_v) begin errs++; $display("FAIL reset[%0d] got %h want %h", i, obs, exp_v); end
        end
        rst = 1'b0;
        b.req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        b.wdata = 32'h00A50000;
        b.req = 4'b0100;
        tick();
        exp_v = {4'b0100, 4'b0000, 8'h00, 8'hFF, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL single_grant got %h want %h", obs, exp_v); end
        tick();
        exp_v = {4'b0100, 4'b0100, 8'hA5, 8'h5A, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL single_ack got %h want %h", obs, exp_v); end
        b.req = 4'b0000;
        tick();
        exp_v = {4'b0000, 4'b0000, 8'hA5, 8'h5A, 1'b0};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL single_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_fairness();
        logic [3:0] g;
        logic [7:0] d;
        do_reset();
        b.wdata = 32'h44332211;
        b.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << (i % 4);
            d = 8'(8'h11 * ((i % 4) + 1));
            tick();
            vec++;
            if (b.gnt !== g || b.ack !== 4'b0000) begin errs++; $display("FAIL fair_grant[%0d] got gnt=%b ack=%b want gnt=%b ack=0000", i, b.gnt, b.ack, g); end
            tick();
            vec++;
            if (b.ack !== g || b.q !== d || b.qb !== ~d) begin errs++; $display("FAIL fair_write[%0d] got ack=%b q=%h qb=%h want ack=%b q=%h", i, b.ack, b.q, b.qb, g, d); end
            b.req = 4'b1111 & ~g;
            tick();
            b.req = 4'b1111;
        end
        b.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_withdrawal();
        do_reset();
        b.wdata = 32'h0077_3C00;
        b.req = 4'b0010;
        tick();
        exp_v = {4'b0010, 4'b0000, 8'h00, 8'hFF, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wd_grant got %h want %h", obs, exp_v); end
        b.req = 4'b0000;
        tick();
        exp_v = {4'b0000, 4'b0000, 8'h00, 8'hFF, 1'b0};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wd_abort got %h want %h", obs, exp_v); end
        b.req = 4'b0110;
        tick();
        vec++;
        if (b.gnt !== 4'b0010) begin errs++; $display("FAIL wd_ptr_kept got gnt=%b want 0010", b.gnt); end
        tick();
        exp_v = {4'b0010, 4'b0010, 8'h3C, 8'hC3, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wd_retry got %h want %h", obs, exp_v); end
        b.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        b.wdata = 32'h00F0_0000;
        b.req = 4'b0100;
        tick();
        vec++;
        if (b.gnt !== 4'b0100) begin errs++; $display("FAIL rmid_grant got gnt=%b want 0100", b.gnt); end
        rst = 1'b1;
        tick();
        exp_v = {4'b0000, 4'b0000, 8'h00, 8'hFF, 1'b0};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL rmid_abort got %h want %h", obs, exp_v); end
        rst = 1'b0;
        b.wdata = 32'h00F0_0099;
        b.req = 4'b1111;
        tick();
        vec++;
        if (b.gnt !== 4'b0001) begin errs++; $display("FAIL rmid_next got gnt=%b want 0001", b.gnt); end
        tick();
        vec++;
        if (b.ack !== 4'b0001 || b.q !== 8'h99) begin errs++; $display("FAIL rmid_write got ack=%b q=%h want ack=0001 q=99", b.ack, b.q); end
        b.req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        b.wdata = 32'hD300_00B0;
        b.req = 4'b1000;
        tick();
        tick();
        vec++;
        if (b.ack !== 4'b1000 || b.q !== 8'hD3) begin errs++; $display("FAIL wrap_r3 got ack=%b q=%h want ack=1000 q=d3", b.ack, b.q); end
        b.req = 4'b0000;
        tick();
        b.req = 4'b1001;
        tick();
        vec++;
        if (b.gnt !== 4'b0001) begin errs++; $display("FAIL wrap_first got gnt=%b want 0001", b.gnt); end
        tick();
        exp_v = {4'b0001, 4'b0001, 8'hB0, 8'h4F, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_w0 got %h want %h", obs, exp_v); end
        b.req = 4'b1000;
        tick();
        tick();
        vec++;
        if (b.gnt !== 4'b1000) begin errs++; $display("FAIL wrap_second got gnt=%b want 1000", b.gnt); end
        tick();
        exp_v = {4'b1000, 4'b1000, 8'hD3, 8'h2C, 1'b1};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_w3 got %h want %h", obs, exp_v); end
        b.req = 4'b0000;
        tick();
        exp_v = {4'b0000, 4'b0000, 8'hD3, 8'h2C, 1'b0};
        vec++;
        if (obs !== exp_v) begin errs++; $display("FAIL wrap_idle got %h want %h", obs, exp_v); end
    endtask

    initial begin
        b.req = 4'b0000;
        b.wdata = '0;
        test_reset();
        test_single();
        test_fairness();
        test_withdrawal();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
